// File: rtl/sub_serial_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_serial_pkg;

    // Controller states: waiting, shifting one bit per clock, result pulse.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int SUB_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/sub_serial_fsub1.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout = borrow out.
module fsub1 (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference is the 3-way parity; borrow when y (plus incoming borrow) exceeds x.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: a - b, LSB first, one bit per clock, start/busy/done handshake.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ar_q, ar_d;
    logic [WIDTH-1:0] br_q, br_d;
    logic [WIDTH-1:0] dr_q, dr_d;
    logic             bw_q, bw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] dr_shift;

    fsub1 u_fsub1 (
        .x    (ar_q[0]),
        .y    (br_q[0]),
        .bin  (bw_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // New difference bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
    always_comb begin
        dr_shift = (dr_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
    end

    // Next-state and datapath; results are committed only on the last shift edge.
    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        br_d     = br_q;
        dr_d     = dr_q;
        bw_d     = bw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ar_d    = a;
                    br_d    = b;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                bw_d  = bit_bout;
                dr_d  = dr_shift;
                ar_d  = ar_q >> 1;
                br_d  = br_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = ST_DONE;
                    diff_d   = dr_shift;
                    borrow_d = bit_bout;
                    zero_d   = (dr_shift == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake outputs are registered copies of the state being entered.
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ar_q     <= '0;
            br_q     <= '0;
            dr_q     <= '0;
            bw_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ar_q     <= ar_d;
            br_q     <= br_d;
            dr_q     <= dr_d;
            bw_q     <= bw_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial (WIDTH=4): stimulus pushes expected results, a monitor pops on done.
module tb_sub_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a, b;
    logic       busy, done, borrow, zero;
    logic [3:0] diff;

    typedef struct packed {
        logic [3:0] rdiff;
        logic       rborrow;
        logic       rzero;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;

    sub_serial #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            check("busy_in_done", {31'd0, busy}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("diff", {28'd0, diff}, {28'd0, e.rdiff});
                check("borrow", {31'd0, borrow}, {31'd0, e.rborrow});
                check("zero", {31'd0, zero}, {31'd0, e.rzero});
            end
        end
    end

    // Drive one start pulse (called just after a rising edge); returns in the first SHIFT cycle.
    task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ed,
                         input logic eb, input logic ez, input bit push);
        a = ia; b = ib; start = 1'b1;
        if (push) sb_q.push_back('{rdiff: ed, rborrow: eb, rzero: ez});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Full operation with latency checks: busy for 4 cycles, done in the 5th, idle after.
    task automatic op(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ed,
                      input logic eb, input logic ez);
        issue(ia, ib, ed, eb, ez, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", i + 1), {31'd0, busy}, 32'd1);
            check($sformatf("nodone_c%0d", i + 1), {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        check("done_c5", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("done_c6", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {28'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic vectors: 5-3, 3-5, 7-7, 0-15.
        op(4'd5, 4'd3, 4'h2, 1'b0, 1'b0);
        op(4'd3, 4'd5, 4'hE, 1'b1, 1'b0);
        op(4'd7, 4'd7, 4'h0, 1'b0, 1'b1);
        check("hold_zero", {31'd0, zero}, 32'd1);
        op(4'd0, 4'd15, 4'h1, 1'b1, 1'b0);
        check("hold_diff", {28'd0, diff}, 32'h1);

        // start and operand changes while busy are ignored.
        d0 = n_done;
        issue(4'd9, 4'd4, 4'h5, 1'b0, 1'b0, 1'b1);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 4'd15; b = 4'd15;
        repeat (8) @(posedge clk);
        #1;
        check("busy_start_done_cnt", n_done - d0, 32'd1);

        // Back-to-back with start held through DONE: done at cycles 5 and 10.
        a = 4'd8; b = 4'd2; start = 1'b1;
        sb_q.push_back('{rdiff: 4'h6, rborrow: 1'b0, rzero: 1'b0});
        sb_q.push_back('{rdiff: 4'h6, rborrow: 1'b0, rzero: 1'b0});
        @(posedge clk); #1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check($sformatf("b2b_done_c%0d", c), {31'd0, done}, {31'd0, (c == 5 || c == 10)});
            if (c == 5) begin
                check("b2b_no_idle", {31'd0, busy}, 32'd0);
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        @(posedge clk); #1;

        // Reset mid-operation clears everything at once, no done pulse.
        op(4'd6, 4'd1, 4'h5, 1'b0, 1'b0);
        d0 = n_done;
        issue(4'd6, 4'd2, 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_diff", {28'd0, diff}, 32'd0);
        check("arst_borrow", {31'd0, borrow}, 32'd0);
        check("arst_zero", {31'd0, zero}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("arst_no_done", n_done - d0, 32'd0);
        check("arst_idle_busy", {31'd0, busy}, 32'd0);
        op(4'd6, 4'd2, 4'h4, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial subtractor: computes A − B, LSB first, one bit per clock. Reports difference, borrow-out and zero flag.
- Companion to the combinational 4-bit adder in the tt_um top level. It performs the inverse operation with a start/busy/done handshake.
- The top wrapper drives it from ui_in (operands) and rst = ~rst_n. Results go to uo_out.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range ≥1).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- start  input  1  request: latch a and b and begin; sampled only in IDLE or DONE
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- busy  output  1  high while the operation is in progress (SHIFT state)
- done  output  1  single-cycle pulse when a result is committed
- diff  output  WIDTH  registered result (a − b) mod 2^WIDTH
- borrow  output  1  registered borrow-out; 1 when a < b (unsigned)
- zero  output  1  registered flag; 1 when diff == 0

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high (rst).
- On reset (at any time, including mid-operation):
  - state = IDLE
  - working registers and bit counter cleared
  - busy = 0, done = 0, diff = 0, borrow = 0, zero = 0
  - any in-flight operation is abandoned with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy = 0, done = 0.
  - If start = 1 at a clock edge: ar ← a, br ← b, bw ← 0, cnt ← 0, go to SHIFT.
- SHIFT (busy = 1): on each edge:
  - d = ar[0] ^ br[0] ^ bw
  - bw ← (~ar[0] & br[0]) | (~(ar[0] ^ br[0]) & bw)
  - dr ← {d, dr[WIDTH-1:1]}
  - ar and br shift right by 1
  - cnt ← cnt + 1
  - When cnt == WIDTH−1, go to DONE on the same edge, and commit the outputs:
    - diff ← final dr value (including this cycle's d)
    - borrow ← final bw
    - zero ← (final dr == 0)
- DONE:
  - done = 1 for exactly this cycle; busy = 0.
  - If start = 1: relatch a and b and go to SHIFT (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- Latency:
  - start sampled at edge k.
  - busy high in cycles k+1 … k+WIDTH.
  - done high in cycle k+WIDTH+1; diff, borrow and zero are valid from that cycle.
  - Throughput: one result per WIDTH+1 cycles.
- Output hold:
  - diff, borrow and zero change only on commit or reset.
  - They hold their values through IDLE and through the next operation until its commit.
- start while busy = 1 is ignored. No queuing; the operands are not resampled.
- a and b are sampled only on the accepting edge. Changes afterwards do not affect the result.
- cnt width is clog2(WIDTH), minimum 1. WIDTH = 1 gives a single SHIFT cycle.
- Arithmetic is unsigned modulo 2^WIDTH. The borrow is the unsigned underflow indication.

Decomposition:
- Shared package sub_serial_pkg:
  - state typedef (IDLE, SHIFT, DONE) as a 2-bit enum
  - localparam SUB_WIDTH_DEFAULT = 4
- One natural sub-module: fsub1, a combinational 1-bit full subtractor.
  - Inputs: x, y, bin. Outputs: d, bout.
  - Instantiated once for the serial datapath.

Test Plan:
- a=5, b=3, start pulse → busy for 4 cycles, then done pulse; diff=2, borrow=0, zero=0.
- a=3, b=5 → diff=4'hE, borrow=1, zero=0.
- a=7, b=7 → diff=0, borrow=0, zero=1. Then a=0, b=15 → diff=1, borrow=1, zero=0.
- Start a=9, b=4. Pulse start again with a=1, b=1 while busy; also change a and b mid-operation → those changes are ignored; single result diff=5, done exactly once.
- start held high through the DONE cycle with a=8, b=2 → second operation begins with no IDLE cycle; done pulses at cycles 5 and 10 after the first accept; the second result is diff=6.
- First run a=6, b=1 to commit diff=5. Then start a=6, b=2 and assert rst in the 2nd SHIFT cycle → all outputs 0 immediately (asynchronous), state IDLE, no done pulse. A fresh start a=6, b=2 after reset release → diff=4.
